// File: rtl/fifo_serializer_pkg.sv
// Shared definitions for the FIFO-fed serializer: FSM state encoding and default sizing.
// The PARITY encoding is reserved here; the FSM only visits it when FIFO_SERIALIZER_PARITY_EN is defined.
package fifo_serializer_pkg;

    localparam int DEFAULT_WIDTH        = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

endpackage

// File: rtl/fifo_serializer_bit_timer.sv
// bit_timer: free-running 0..CLKS_PER_BIT-1 counter that pulses tick on its last count.
// Holding clear parks the count at zero so the first bit of a frame gets its full length.
module bit_timer
    import fifo_serializer_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || (cnt_q == LAST_CNT)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST_CNT);

endmodule

// File: rtl/fifo_serializer.sv
// fifo_serializer: pulls words from an upstream FIFO with a four-phase rx_rdy/rx_done handshake
// and sends them LSB first as start/data/[parity]/stop frames. Parity via FIFO_SERIALIZER_PARITY_EN.
module fifo_serializer
    import fifo_serializer_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_rdy,
    input  logic [WIDTH-1:0] in_data,
    output logic             rx_done,
    output logic             txd,
    output logic             busy
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic             rx_done_q;
    logic             rx_done_d;
`ifdef FIFO_SERIALIZER_PARITY_EN
    logic             parity_q;
    logic             parity_d;
`endif

    logic tick;
    logic capture;

    // The timer is held in IDLE so START always begins from count zero.
    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(state_q == IDLE),
        .tick (tick)
    );

    // A word is taken only once the previous handshake has fully closed (rx_done low).
    assign capture = (state_q == IDLE) && rx_rdy && !rx_done_q;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        rx_done_d = rx_done_q;
`ifdef FIFO_SERIALIZER_PARITY_EN
        parity_d  = parity_q;
`endif

        if (capture) begin
            rx_done_d = 1'b1;
        end else if (!rx_rdy) begin
            rx_done_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d  = START;
                    shift_d  = in_data;
                    idx_d    = '0;
`ifdef FIFO_SERIALIZER_PARITY_EN
                    parity_d = ^in_data;
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
`ifdef FIFO_SERIALIZER_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
`ifdef FIFO_SERIALIZER_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            idx_q     <= '0;
            rx_done_q <= 1'b0;
`ifdef FIFO_SERIALIZER_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            rx_done_q <= rx_done_d;
`ifdef FIFO_SERIALIZER_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // Line level is decoded from registered state, so reset drives it high without a clock.
    always_comb begin
        txd = 1'b1;
        case (state_q)
            START:   txd = 1'b0;
            DATA:    txd = shift_q[0];
`ifdef FIFO_SERIALIZER_PARITY_EN
            PARITY:  txd = parity_q;
`endif
            default: txd = 1'b1;
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign rx_done = rx_done_q;

endmodule

// File: tb/tb_fifo_serializer.sv
// Self-checking bench for fifo_serializer (WIDTH=8, CLKS_PER_BIT=4); a scoreboard process
// checks every frame bit-by-bit against queued words. Define FIFO_SERIALIZER_PARITY_EN for the parity build.
module tb_fifo_serializer;

    localparam int W   = 8;
    localparam int CPB = 4;
`ifdef FIFO_SERIALIZER_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FRAME_BITS = 2 + W + P;
    localparam int WAIT_LIMIT = FRAME_BITS * CPB * 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rx_rdy;
    logic [W-1:0] in_data;
    logic         rx_done;
    logic         txd;
    logic         busy;

    int           checks = 0;
    int           errors = 0;
    int           framesDone = 0;
    bit           monitorEn = 1'b0;
    logic [W-1:0] expQ[$];

    fifo_serializer #(
        .WIDTH       (W),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rx_rdy (rx_rdy),
        .in_data(in_data),
        .rx_done(rx_done),
        .txd    (txd),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Scoreboard: a frame starts on the first negedge with busy high; every cycle of every bit is checked,
    // and busy must be low on the cycle right after the last stop cycle (exact frame length).
    initial begin : scoreboard
        logic [W-1:0] word;
        logic         expBit;
        forever begin
            @(negedge clk);
            if (monitorEn && rst_n === 1'b1 && busy === 1'b1) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL frame_unexpected: busy=%b with %0d words queued, required 0 frames", busy, expQ.size());
                    for (int i = 0; i < WAIT_LIMIT && busy === 1'b1; i++) @(negedge clk);
                end else begin
                    word = expQ.pop_front();
                    for (int b = 0; b < FRAME_BITS; b++) begin
                        for (int c = 0; c < CPB; c++) begin
                            if (b != 0 || c != 0) @(negedge clk);
                            if (b == 0)                       expBit = 1'b0;
                            else if (b <= W)                  expBit = word[b-1];
                            else if (P == 1 && b == W + 1)    expBit = ^word;
                            else                              expBit = 1'b1;
                            checks++;
                            if (txd !== expBit || busy !== 1'b1) begin
                                errors++;
                                $display("[TB] FAIL frame_bit word=%h bit=%0d cyc=%0d: txd=%b busy=%b, required txd=%b busy=1",
                                         word, b, c, txd, busy, expBit);
                            end
                        end
                    end
                    @(negedge clk);
                    checks++;
                    if (busy !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL frame_length word=%h: busy=%b after %0d cycles, required 0", word, busy, FRAME_BITS * CPB);
                    end
                    framesDone++;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [W-1:0] word, input bit pushExp);
        in_data = word;
        rx_rdy  = 1'b1;
        if (pushExp) expQ.push_back(word);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        rx_rdy  = 1'b0;
        in_data = '0;
        #2;
        checks++;
        if (txd !== 1'b1) begin errors++; $display("[TB] FAIL reset_txd: got %b, required 1", txd); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, required 0", busy); end
        checks++;
        if (rx_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_rx_done: got %b, required 0", rx_done); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_idle();
        rx_rdy = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++;
            if (txd !== 1'b1 || busy !== 1'b0 || rx_done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL idle cyc=%0d: txd=%b busy=%b rx_done=%b, required 1/0/0", i, txd, busy, rx_done);
            end
        end
        // rx_rdy pulses between clock edges, so it is never sampled and nothing may be taken.
        @(posedge clk);
        #1 applyStimulus(8'hE7, 1'b0);
        #2 rx_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || rx_done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL idle_glitch cyc=%0d: busy=%b rx_done=%b, required 0/0", i, busy, rx_done);
            end
        end
    endtask

    task automatic test_basic();
        int target;
        target = framesDone + 1;
        @(negedge clk);
        applyStimulus(8'hA5, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (rx_done !== 1'b1 || txd !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_capture: rx_done=%b txd=%b busy=%b, required 1/0/1", rx_done, txd, busy);
        end
        @(negedge clk);
        rx_rdy = 1'b0;
        for (int i = 0; i < WAIT_LIMIT && framesDone < target; i++) @(negedge clk);
        checks++;
        if (framesDone < target) begin
            errors++;
            $display("[TB] FAIL basic_timeout: frames=%0d, required %0d", framesDone, target);
        end
    endtask

    task automatic test_handshake_hold();
        int target;
        target = framesDone + 1;
        @(negedge clk);
        applyStimulus(8'h96, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (rx_done !== 1'b1) begin errors++; $display("[TB] FAIL hold_ack: rx_done=%b, required 1", rx_done); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (rx_done !== 1'b1) begin
                errors++;
                $display("[TB] FAIL hold_rx_done cyc=%0d: rx_done=%b, required 1", i, rx_done);
            end
        end
        rx_rdy = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (rx_done !== 1'b0) begin errors++; $display("[TB] FAIL hold_release: rx_done=%b, required 0", rx_done); end
        for (int i = 0; i < WAIT_LIMIT && framesDone < target; i++) @(negedge clk);
        checks++;
        if (framesDone < target) begin
            errors++;
            $display("[TB] FAIL hold_timeout: frames=%0d, required %0d", framesDone, target);
        end
    endtask

    task automatic test_back_to_back();
        int target;
        int lowCnt;
        bit sawLow;
        bit done;
        bit lowTxdBad;
        target    = framesDone + 2;
        lowCnt    = 0;
        sawLow    = 1'b0;
        done      = 1'b0;
        lowTxdBad = 1'b0;
        @(negedge clk);
        applyStimulus(8'h3C, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (rx_done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ack1: rx_done=%b, required 1", rx_done); end
        @(negedge clk);
        rx_rdy = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (rx_done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_release1: rx_done=%b, required 0", rx_done); end
        @(negedge clk);
        applyStimulus(8'hC3, 1'b1);
        // Only the single IDLE cycle (the capture edge) may separate the first stop bit from the second start bit.
        for (int i = 0; i < WAIT_LIMIT && !done; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                lowCnt++;
                sawLow = 1'b1;
                if (txd !== 1'b1) lowTxdBad = 1'b1;
            end else if (sawLow) begin
                done = 1'b1;
            end
        end
        checks++;
        if (!done) begin errors++; $display("[TB] FAIL b2b_second_start: seen=%b, required 1", done); end
        checks++;
        if (lowCnt != 1) begin errors++; $display("[TB] FAIL b2b_gap: idle cycles=%0d, required 1", lowCnt); end
        checks++;
        if (lowTxdBad) begin errors++; $display("[TB] FAIL b2b_gap_txd: txd low between frames, required 1"); end
        checks++;
        if (rx_done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ack2: rx_done=%b, required 1", rx_done); end
        rx_rdy = 1'b0;
        for (int i = 0; i < WAIT_LIMIT && framesDone < target; i++) @(negedge clk);
        checks++;
        if (framesDone < target) begin
            errors++;
            $display("[TB] FAIL b2b_timeout: frames=%0d, required %0d", framesDone, target);
        end
    endtask

`ifdef FIFO_SERIALIZER_PARITY_EN
    task automatic test_parity();
        logic [W-1:0] words [2];
        logic         parExp[2];
        int           target;
        words[0] = 8'hA5; parExp[0] = 1'b0;
        words[1] = 8'h01; parExp[1] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            target = framesDone + 1;
            @(negedge clk);
            applyStimulus(words[k], 1'b1);
            @(negedge clk);
            rx_rdy = 1'b0;
            // Now in frame cycle 0; cycle 37 sits inside the parity bit (bit 9, cycles 36..39).
            repeat (37) @(negedge clk);
            checks++;
            if (txd !== parExp[k] || busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL parity word=%h: txd=%b busy=%b, required txd=%b busy=1", words[k], txd, busy, parExp[k]);
            end
            for (int i = 0; i < WAIT_LIMIT && framesDone < target; i++) @(negedge clk);
            checks++;
            if (framesDone < target) begin
                errors++;
                $display("[TB] FAIL parity_timeout word=%h: frames=%0d, required %0d", words[k], framesDone, target);
            end
        end
    endtask
`endif

    task automatic test_reset_abort();
        int target;
        monitorEn = 1'b0;
        @(negedge clk);
        applyStimulus(8'hFF, 1'b0);
        @(negedge clk);
        // Frame cycle 0; cycle 17 lies in data bit 3 (frame bit 4, cycles 16..19).
        repeat (17) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || rx_done !== 1'b1 || txd !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_pre: busy=%b rx_done=%b txd=%b, required 1/1/1", busy, rx_done, txd);
        end
        #1;
        rst_n  = 1'b0;
        rx_rdy = 1'b0;
        #1;
        checks++;
        if (txd !== 1'b1) begin errors++; $display("[TB] FAIL abort_txd: got %b, required 1", txd); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b, required 0", busy); end
        checks++;
        if (rx_done !== 1'b0) begin errors++; $display("[TB] FAIL abort_rx_done: got %b, required 0", rx_done); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || txd !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_release: busy=%b txd=%b, required 0/1", busy, txd);
        end
        monitorEn = 1'b1;
        target = framesDone + 1;
        applyStimulus(8'h55, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (rx_done !== 1'b1) begin errors++; $display("[TB] FAIL abort_recapture: rx_done=%b, required 1", rx_done); end
        @(negedge clk);
        rx_rdy = 1'b0;
        for (int i = 0; i < WAIT_LIMIT && framesDone < target; i++) @(negedge clk);
        checks++;
        if (framesDone < target) begin
            errors++;
            $display("[TB] FAIL abort_timeout: frames=%0d, required %0d", framesDone, target);
        end
    endtask

    initial begin
        test_reset();
        monitorEn = 1'b1;
        test_idle();
        test_basic();
        test_handshake_hold();
        test_back_to_back();
`ifdef FIFO_SERIALIZER_PARITY_EN
        test_parity();
`endif
        test_reset_abort();
        repeat (4) @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL leftover_words: %0d queued, required 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_serializer.md
FIFO_SERIALIZER -- requirements
Module: fifo_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data word width in bits.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 16, giving the clock cycles per serial bit (minimum 2).
REQ-003 Port clk, input, 1: the single clock, rising-edge active.
REQ-004 Port rst_n, input, 1: the reset, asynchronous and active-low.
REQ-005 Port rx_rdy, input, 1: the upstream FIFO has a word on in_data.
REQ-006 Port in_data, input, WIDTH: the upstream FIFO front word, valid while rx_rdy=1.
REQ-007 Port rx_done, output, 1: the acknowledge that the word has been taken.
REQ-008 Port txd, output, 1: the serial line, idle high.
REQ-009 Port busy, output, 1: high whenever a frame is in progress.

Function
REQ-010 The capture condition SHALL be state IDLE, rx_rdy=1 and rx_done=0 at a clock edge.
REQ-011 On capture, the block SHALL do all of the following at that same edge:
- load in_data into the shift register;
- set rx_done=1;
- enter START, so txd=0 from that edge.
REQ-012 rx_done SHALL stay 1 until rx_rdy is sampled 0, and SHALL clear at the edge where rx_rdy=0 is sampled (four-phase handshake).
REQ-013 The rx_done handshake SHALL run independently of serialization.
REQ-014 No new capture SHALL occur while rx_done=1.
REQ-015 The FSM states SHALL be IDLE, START, DATA, PARITY and STOP. PARITY exists only under the configuration macro (REQ-026).
REQ-016 Each state other than IDLE SHALL last exactly CLKS_PER_BIT cycles, timed by a bit counter that counts 0..CLKS_PER_BIT-1 and wraps.
REQ-017 The DATA state SHALL emit WIDTH bits, LSB first, using a bit index of width $clog2(WIDTH).
REQ-018 The state transitions SHALL be START->DATA, then DATA->PARITY or DATA->STOP after bit WIDTH-1, PARITY->STOP, and STOP->IDLE.
REQ-019 txd SHALL be 1 during STOP and IDLE.
REQ-020 Frame length SHALL be (2+WIDTH+P)*CLKS_PER_BIT cycles, where P=1 with parity and P=0 without.
REQ-021 In IDLE, if the capture condition already holds, capture SHALL occur at the first IDLE edge, giving back-to-back frames with no extra idle bit.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 If rx_rdy drops before rx_done is set, nothing SHALL be captured.

Reset
REQ-024 While rst_n=0, the block SHALL force state=IDLE, txd=1, rx_done=0, busy=0 and clear the counters and shift register immediately, without waiting for clk.
REQ-025 An assertion of rst_n mid-frame SHALL abort the frame, and the word SHALL be lost. After release, capture SHALL resume on the next valid capture condition.

Configuration
REQ-026 Macro FIFO_SERIALIZER_PARITY_EN, when defined, SHALL insert the PARITY state carrying the even-parity bit (XOR of the captured word).
REQ-027 Without FIFO_SERIALIZER_PARITY_EN, the PARITY state and its logic SHALL be absent and DATA SHALL go directly to STOP.

Structure
REQ-028 Package fifo_serializer_pkg SHALL hold the FSM state typedef with fixed encodings (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4), plus the default WIDTH and CLKS_PER_BIT constants.
REQ-029 Sub-module bit_timer SHALL implement the CLKS_PER_BIT counter. Its inputs SHALL be clk, rst_n and clear, and it SHALL output a one-cycle tick at count CLKS_PER_BIT-1.
REQ-030 fifo_serializer SHALL contain all FSM, handshake and shift logic.

Verification (CLKS_PER_BIT=4, WIDTH=8)
REQ-031 The bench SHALL drive rx_rdy=1 with in_data=0xA5, parity off, and SHALL check:
- rx_done=1 one edge later;
- txd = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles;
- busy high for 40 cycles.
REQ-032 The bench SHALL repeat 0xA5 with FIFO_SERIALIZER_PARITY_EN defined and check a parity bit of 0 before stop, for a 44-cycle frame. It SHALL then send 0x01 and check a parity bit of 1.
REQ-033 The bench SHALL hold rx_rdy=1 for two 1-edge-apart handshakes carrying 0x3C then 0xC3, and check:
- the second start bit immediately follows the first stop bit;
- no idle gap between the frames.
REQ-034 The bench SHALL keep rx_rdy=1 for 10 cycles after capture and check rx_done stays 1. It SHALL then drop rx_rdy and check rx_done=0 on the next edge.
REQ-035 The bench SHALL pulse rst_n=0 during bit 3 of 0xFF and check:
- txd=1, busy=0 and rx_done=0 before the next clk edge;
- a fresh capture of 0x55 after release produces a correct frame.
REQ-036 The bench SHALL keep rx_rdy=0 for 50 cycles and check txd=1, busy=0 and rx_done=0 throughout.
